// File: rtl/snap_trig_capture_ctrl.sv
// Snapshot capture controller: arms on a ctrl[0] rising edge, qualifies a trigger,
// applies the signed trigger offset (post-trigger delay or pre-trigger history) and writes BRAM.
module snap_trig_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic [31:0]       trig_offset,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

  state_t            state;
  logic              arm_prev;
  logic              pre_mode;
  logic [ADDR_W-1:0] n_lim;
  logic [30:0]       delay_cnt;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] remain;
  logic [ADDR_W-1:0] trig_addr;

  logic              arm_edge;
  logic              eff_trig;
  logic              pre_hit;
  logic [31:0]       neg_offset;
  logic [ADDR_W-1:0] clamp_n;
  logic [ADDR_W-1:0] pre_remain;
  logic [31:0]       status_next;
  logic              ctrl_unused;

  assign ctrl_unused = ^ctrl[31:2];
  assign done        = status[31];

  // History length is clamped to DEPTH-1 so at least the trigger sample fits in the buffer.
  always_comb begin
    arm_edge    = ctrl[0] & ~arm_prev;
    eff_trig    = we & (trig | ctrl[1]);
    neg_offset  = 32'd0 - trig_offset;
    clamp_n     = (neg_offset >= 32'(DEPTH - 1)) ? LAST : neg_offset[ADDR_W-1:0];
    pre_remain  = LAST - n_lim;
    pre_hit     = eff_trig & (fill >= n_lim);
    status_next = '0;
    status_next[31] = (state == DONE);
    status_next[30] = (state == ARMED) || (state == DELAY) || (state == CAPTURE);
    status_next[ADDR_W-1:0] = trig_addr;
  end

  // Status is built from the current state, so it trails state changes by one cycle.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state     <= IDLE;
      arm_prev  <= 1'b0;
      pre_mode  <= 1'b0;
      n_lim     <= '0;
      delay_cnt <= '0;
      fill      <= '0;
      wr_addr   <= '0;
      remain    <= '0;
      trig_addr <= '0;
      bram_addr <= '0;
      bram_data <= '0;
      bram_we   <= 1'b0;
      status    <= '0;
    end else begin
      arm_prev <= ctrl[0];
      bram_we  <= 1'b0;
      status   <= status_next;

      case (state)
        IDLE, DONE: begin
          if (arm_edge) begin
            pre_mode  <= trig_offset[31];
            n_lim     <= clamp_n;
            delay_cnt <= trig_offset[30:0];
            fill      <= '0;
            wr_addr   <= '0;
            trig_addr <= '0;
            state     <= ARMED;
          end
        end

        ARMED: begin
          if (!pre_mode) begin
            if (eff_trig) begin
              if (delay_cnt == 31'd0) begin
                bram_we   <= 1'b1;
                bram_addr <= wr_addr;
                bram_data <= din;
                wr_addr   <= wr_addr + ADDR_ONE;
                remain    <= LAST;
                state     <= CAPTURE;
              end else begin
                state <= DELAY;
              end
            end
          end else if (we) begin
            // Pre-trigger history is written circularly until a qualified trigger arrives.
            bram_we   <= 1'b1;
            bram_addr <= wr_addr;
            bram_data <= din;
            wr_addr   <= wr_addr + ADDR_ONE;
            if (pre_hit) begin
              trig_addr <= wr_addr;
              remain    <= pre_remain;
              state     <= (pre_remain == '0) ? DONE : CAPTURE;
            end else if (fill < n_lim) begin
              fill <= fill + ADDR_ONE;
            end
          end
        end

        DELAY: begin
          if (we) begin
            if (delay_cnt == 31'd1) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_addr;
              bram_data <= din;
              wr_addr   <= wr_addr + ADDR_ONE;
              remain    <= LAST;
              state     <= CAPTURE;
            end else begin
              delay_cnt <= delay_cnt - 31'd1;
            end
          end
        end

        CAPTURE: begin
          if (we) begin
            bram_we   <= 1'b1;
            bram_addr <= wr_addr;
            bram_data <= din;
            wr_addr   <= wr_addr + ADDR_ONE;
            remain    <= remain - ADDR_ONE;
            if (remain == ADDR_ONE) state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snap_trig_capture_ctrl.sv
// Directed bench for snap_trig_capture_ctrl: post/pre offset captures, clamping,
// immediate trigger with gapped valid, mid-capture reset, re-arm from done.
module tb_snap_trig_capture_ctrl;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] ctrl = '0;
  logic [31:0] trig_offset = '0;
  logic [31:0] din = '0;
  logic        we = 1'b0;
  logic        trig = 1'b0;
  logic [9:0]  bram_addr;
  logic [31:0] bram_data;
  logic        bram_we;
  logic [31:0] status;
  logic        done;

  int          vectors = 0;
  int          miscompares = 0;

  int          wr_count;
  int          addr_err;
  int          data_err;
  int          we_viol;
  logic [9:0]  exp_addr;
  logic [9:0]  last_addr;
  logic [31:0] seq;

  snap_trig_capture_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl       (ctrl),
    .trig_offset(trig_offset),
    .din        (din),
    .we         (we),
    .trig       (trig),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .status     (status),
    .done       (done)
  );

  always #5 user_clk = ~user_clk;

  // One clock; outputs are looked at 1ns after the edge and every write is logged.
  task automatic tick();
    logic        w;
    logic [31:0] d;
    w = we;
    d = din;
    @(posedge user_clk);
    #1;
    if (bram_we) begin
      wr_count++;
      if (bram_addr !== exp_addr) addr_err++;
      if (bram_data !== d) data_err++;
      if (!w) we_viol++;
      last_addr = bram_addr;
      exp_addr  = exp_addr + 10'd1;
    end
  endtask

  task automatic clear_stats();
    wr_count = 0;
    addr_err = 0;
    data_err = 0;
    we_viol  = 0;
    exp_addr = '0;
  endtask

  task automatic sample(input logic t);
    din  = seq;
    we   = 1'b1;
    trig = t;
    tick();
    seq  = seq + 32'd1;
    trig = 1'b0;
  endtask

  task automatic idle();
    we   = 1'b0;
    trig = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [31:0] off);
    trig_offset = off;
    we      = 1'b0;
    trig    = 1'b0;
    ctrl[0] = 1'b1;
    tick();
    ctrl[0] = 1'b0;
    tick();
    clear_stats();
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    tick();
    tick();
    user_rst = 1'b0;
    tick();
    vectors++; if (bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %0b expected 0", bram_we); end
    vectors++; if (bram_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %0h expected 0", bram_addr); end
    vectors++; if (bram_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_data: got %0h expected 0", bram_data); end
    vectors++; if (status !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_status: got %0h expected 0", status); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
  endtask

  task automatic test_post_zero();
    arm(32'd0);
    vectors++; if (status !== 32'h4000_0000) begin miscompares++; $display("[TB] FAIL post0_busy: got %0h expected 40000000", status); end
    seq = 32'h1000_0000;
    for (int i = 0; i < 4; i++) sample(1'b0);
    vectors++; if (wr_count !== 0) begin miscompares++; $display("[TB] FAIL post0_prewrites: got %0d expected 0", wr_count); end
    sample(1'b1);
    vectors++; if (bram_we !== 1'b1 || bram_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL post0_first_addr: got we=%0b addr=%0h expected we=1 addr=0", bram_we, bram_addr); end
    vectors++; if (bram_data !== 32'h1000_0004) begin miscompares++; $display("[TB] FAIL post0_first_data: got %0h expected 10000004", bram_data); end
    for (int i = 0; i < 1023; i++) sample(1'b0);
    vectors++; if (bram_addr !== 10'd1023 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL post0_last: got addr=%0h done=%0b expected addr=3ff done=0", bram_addr, done); end
    vectors++; if (wr_count !== 1024) begin miscompares++; $display("[TB] FAIL post0_count: got %0d expected 1024", wr_count); end
    vectors++; if (addr_err !== 0 || data_err !== 0) begin miscompares++; $display("[TB] FAIL post0_seq: got addr_err=%0d data_err=%0d expected 0/0", addr_err, data_err); end
    idle();
    vectors++; if (done !== 1'b1 || status !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL post0_done: got done=%0b status=%0h expected 1/80000000", done, status); end
    for (int i = 0; i < 3; i++) sample(1'b1);
    vectors++; if (wr_count !== 1024) begin miscompares++; $display("[TB] FAIL post0_after_done: got %0d expected 1024", wr_count); end
  endtask

  task automatic test_post_delay();
    arm(32'd3);
    seq = 32'h2000_0000;
    sample(1'b0);
    sample(1'b0);
    sample(1'b1);
    sample(1'b0);
    sample(1'b0);
    vectors++; if (wr_count !== 0) begin miscompares++; $display("[TB] FAIL delay_nowrite: got %0d expected 0", wr_count); end
    sample(1'b0);
    vectors++; if (bram_we !== 1'b1 || bram_addr !== 10'd0 || bram_data !== 32'h2000_0005) begin miscompares++; $display("[TB] FAIL delay_first: got we=%0b addr=%0h data=%0h expected 1/0/20000005", bram_we, bram_addr, bram_data); end
    for (int i = 0; i < 1023; i++) sample(1'b0);
    vectors++; if (wr_count !== 1024 || addr_err !== 0 || data_err !== 0) begin miscompares++; $display("[TB] FAIL delay_count: got %0d writes err=%0d/%0d expected 1024 0/0", wr_count, addr_err, data_err); end
    idle();
    vectors++; if (status !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL delay_done: got %0h expected 80000000", status); end
  endtask

  task automatic test_pre();
    arm(-32'sd16);
    seq = 32'h3000_0000;
    for (int i = 0; i < 8; i++) sample(1'b0);
    sample(1'b1);
    vectors++; if (wr_count !== 9 || bram_addr !== 10'd8) begin miscompares++; $display("[TB] FAIL pre_early_trig: got %0d writes addr=%0h expected 9 addr=8", wr_count, bram_addr); end
    idle();
    vectors++; if (status !== 32'h4000_0000) begin miscompares++; $display("[TB] FAIL pre_still_armed: got %0h expected 40000000", status); end
    for (int i = 0; i < 11; i++) sample(1'b0);
    sample(1'b1);
    vectors++; if (bram_addr !== 10'd20 || bram_data !== 32'h3000_0014) begin miscompares++; $display("[TB] FAIL pre_trig_write: got addr=%0h data=%0h expected 14/30000014", bram_addr, bram_data); end
    sample(1'b0);
    vectors++; if (status !== 32'h4000_0014) begin miscompares++; $display("[TB] FAIL pre_trig_addr: got %0h expected 40000014", status); end
    for (int i = 0; i < 1006; i++) sample(1'b0);
    vectors++; if (wr_count !== 1028 || last_addr !== 10'd3) begin miscompares++; $display("[TB] FAIL pre_total: got %0d writes last=%0h expected 1028 last=3", wr_count, last_addr); end
    vectors++; if (addr_err !== 0 || data_err !== 0) begin miscompares++; $display("[TB] FAIL pre_seq: got addr_err=%0d data_err=%0d expected 0/0", addr_err, data_err); end
    idle();
    vectors++; if (status !== 32'h8000_0014 || done !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_done: got status=%0h done=%0b expected 80000014/1", status, done); end
  endtask

  task automatic test_pre_clamp();
    arm(-32'sd5000);
    seq = 32'h4000_0000;
    for (int i = 0; i < 1022; i++) sample(1'b0);
    sample(1'b1);
    idle();
    vectors++; if (status !== 32'h4000_0000) begin miscompares++; $display("[TB] FAIL clamp_early: got %0h expected 40000000", status); end
    sample(1'b1);
    vectors++; if (bram_addr !== 10'd1023 || wr_count !== 1024) begin miscompares++; $display("[TB] FAIL clamp_trig: got addr=%0h writes=%0d expected 3ff/1024", bram_addr, wr_count); end
    sample(1'b0);
    vectors++; if (done !== 1'b1 || status !== 32'h8000_03FF) begin miscompares++; $display("[TB] FAIL clamp_done: got done=%0b status=%0h expected 1/800003ff", done, status); end
    vectors++; if (wr_count !== 1024) begin miscompares++; $display("[TB] FAIL clamp_single: got %0d expected 1024", wr_count); end
  endtask

  task automatic test_imm_trig();
    ctrl[1] = 1'b1;
    arm(32'd0);
    seq = 32'h5000_0000;
    for (int i = 0; i < 1024; i++) begin
      sample(1'b0);
      idle();
    end
    vectors++; if (wr_count !== 1024 || we_viol !== 0) begin miscompares++; $display("[TB] FAIL imm_count: got %0d writes %0d gapped expected 1024/0", wr_count, we_viol); end
    vectors++; if (addr_err !== 0 || data_err !== 0) begin miscompares++; $display("[TB] FAIL imm_seq: got addr_err=%0d data_err=%0d expected 0/0", addr_err, data_err); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL imm_done: got %0b expected 1", done); end
    ctrl[1] = 1'b0;
  endtask

  task automatic test_rst_mid();
    arm(32'd0);
    seq = 32'h6000_0000;
    sample(1'b1);
    for (int i = 0; i < 99; i++) sample(1'b0);
    ctrl[0] = 1'b1;
    sample(1'b0);
    vectors++; if (bram_we !== 1'b1 || bram_addr !== 10'd100) begin miscompares++; $display("[TB] FAIL rearm_ignored: got we=%0b addr=%0h expected 1/64", bram_we, bram_addr); end
    ctrl[0] = 1'b0;
    sample(1'b0);
    vectors++; if (status !== 32'h4000_0000 || addr_err !== 0) begin miscompares++; $display("[TB] FAIL mid_busy: got %0h addr_err=%0d expected 40000000/0", status, addr_err); end
    user_rst = 1'b1;
    din = seq;
    we  = 1'b1;
    tick();
    vectors++; if (bram_we !== 1'b0 || status !== 32'd0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset: got we=%0b status=%0h done=%0b expected 0/0/0", bram_we, status, done); end
    user_rst = 1'b0;
    for (int i = 0; i < 3; i++) sample(1'b1);
    vectors++; if (wr_count !== 102 || status !== 32'd0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %0d writes status=%0h expected 102/0", wr_count, status); end
  endtask

  task automatic test_rearm_done();
    arm(32'd0);
    seq = 32'h7000_0000;
    sample(1'b1);
    for (int i = 0; i < 1023; i++) sample(1'b0);
    idle();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL rearm_pre_done: got %0b expected 1", done); end
    clear_stats();
    ctrl[0] = 1'b1;
    din  = 32'h7777_0000;
    we   = 1'b1;
    trig = 1'b1;
    tick();
    vectors++; if (bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rearm_trig_ignored: got %0b expected 0", bram_we); end
    ctrl[0] = 1'b0;
    idle();
    vectors++; if (status !== 32'h4000_0000 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL rearm_busy: got %0h done=%0b expected 40000000/0", status, done); end
    seq = 32'h7100_0000;
    sample(1'b1);
    vectors++; if (bram_we !== 1'b1 || bram_addr !== 10'd0 || bram_data !== 32'h7100_0000) begin miscompares++; $display("[TB] FAIL rearm_restart: got we=%0b addr=%0h data=%0h expected 1/0/71000000", bram_we, bram_addr, bram_data); end
  endtask

  initial begin
    clear_stats();
    seq = '0;
    last_addr = '0;
    test_reset();
    test_post_zero();
    test_post_delay();
    test_pre();
    test_pre_clamp();
    test_imm_trig();
    test_rst_mid();
    test_rearm_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snap_trig_capture_ctrl.md
Name: snap_trig_capture_ctrl

Overview:
- Capture controller for the ADC snapshot path, directly downstream of the snapshot trig_offset and ctrl software registers.
- Arms on a software request, qualifies a trigger, applies the signed trigger offset (post-trigger delay or pre-trigger history) and drives the snapshot BRAM write port.
- Reports done, busy and trigger address back through a status word read by software.
- Runs entirely in the user clock domain; register outputs arrive already synchronised to user_clk.

Parameters:
ADDR_W, 10, BRAM address width; capture depth DEPTH = 2^ADDR_W samples
DATA_W, 32, sample width

Ports:
user_clk  in  1  user/DSP clock; all logic on rising edge
user_rst  in  1  synchronous, active-high reset
ctrl  in  32  ctrl register; bit0 arm (rising edge acts), bit1 immediate trigger; other bits ignored
trig_offset  in  32  signed two's-complement offset from trig_offset register
din  in  DATA_W  sample data
we  in  1  sample valid
trig  in  1  external trigger, sampled only when we=1
bram_addr  out  ADDR_W  BRAM write address
bram_data  out  DATA_W  BRAM write data
bram_we  out  1  BRAM write enable
status  out  32  bit31 done, bit30 busy, bits[ADDR_W-1:0] trigger address, other bits 0
done  out  1  capture complete, equals status[31]

Behaviour:
- Reset: state IDLE; bram_addr=0, bram_data=0, bram_we=0, status=0, done=0; arm edge detector cleared.
- Arm event: ctrl[0]=1 while registered previous value was 0. Honoured in IDLE or DONE, ignored otherwise.
  - On arm, the controller latches trig_offset, clears done, clears the trigger address, sets busy, resets the address counter and the fill counter to 0, and enters ARMED.
- Effective trigger: we & (trig | ctrl[1]).
- Offset mode is chosen from the latched value:
  - offset ≥ 0: POST mode; D = offset.
  - offset < 0: PRE mode; N = min(-offset, DEPTH-1).
- States:
  - IDLE: no writes.
  - ARMED, POST: no writes. On effective trigger, go to CAPTURE if D=0; otherwise load delay counter with D and go to DELAY. The trigger sample is written only when D=0.
  - ARMED, PRE: every valid sample is written circularly (address wraps DEPTH-1→0); fill counter saturates at N. An effective trigger is honoured only when fill ≥ N, otherwise ignored. When honoured: write the trigger sample, record its address as the trigger address, load the remaining count DEPTH-N-1, and go to CAPTURE (go to DONE if the remaining count is 0).
  - DELAY: each valid sample decrements the counter; no writes. The valid sample that brings the count to 0 is the first sample written (at address 0), then go to CAPTURE.
  - CAPTURE: each valid sample is written and the address increments. POST writes DEPTH samples at addresses 0..DEPTH-1. PRE writes until the remaining count reaches 0. After the final write go to DONE.
  - DONE: done=1, busy=0, no writes. Only an arm event or reset leaves this state.
- Write latency: bram_we/bram_addr/bram_data are registered, one cycle after the qualifying din/we.
- bram_we is never asserted when we=0.
- Address arithmetic: ADDR_W bits, modulo DEPTH.
- trig_offset and ctrl[1] changes after arm do not affect the current capture, except that ctrl[1] is live in the trigger qualifier.
- Simultaneous events:
  - Arm edge in DONE on the same cycle as a trigger: arm takes effect; the trigger is ignored that cycle.
  - Reset overrides everything.
- Reset mid-capture: returns to IDLE; the partial capture is abandoned; done stays 0.
- status updates one cycle after the state change.

Test Plan:
- Reset → all outputs 0. Arm with offset=0, trigger on the 5th valid sample → 1024 writes, addr 0..1023, first data = 5th sample; done=1 on the cycle after the last write; status=0x8000_0000.
- Arm with offset=+3, trig pulse on valid sample k → no writes for samples k..k+2; sample k+3 goes to addr 0; 1024 writes total; done set.
- Arm with offset=-16, trig asserted after only 8 valid samples → trigger ignored. Trigger after 20 valid samples → trigger sample written at addr 20; 1008 total further writes incl. trigger, addresses wrap; status[9:0]=20; done=1.
- Arm with offset=-5000 → N clamped to 1023; exactly 1 write after fill (the trigger sample); done next cycle.
- Set ctrl[1]=1 with offset=0 and we toggling 1,0,1,0 → writes only on we=1 cycles; 1024 writes; bram_we never high with we=0.
- user_rst asserted mid-CAPTURE → next cycle IDLE, bram_we=0, status=0. A second arm edge during CAPTURE is ignored. Arm from DONE clears done and restarts.
